// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch display constants and helpers
package stopwatch_pkg;

    localparam int DEFAULT_SCAN_DIV = 100000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIG_SEC_ONES = 2'd0;
    localparam digit_idx_t DIG_SEC_TENS = 2'd1;
    localparam digit_idx_t DIG_MIN_ONES = 2'd2;
    localparam digit_idx_t DIG_MIN_TENS = 2'd3;

    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic [3:0] an_onehot_low(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD to active-low 7-segment decoder, dash for 10-15
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment driver with adjust-mode blink
module seg7_scan_driver
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic       blink_tick,
    input  logic [3:0] bcd_min_tens,
    input  logic [3:0] bcd_min_ones,
    input  logic [3:0] bcd_sec_tens,
    input  logic [3:0] bcd_sec_ones,
    input  logic       is_adj,
    input  logic       is_sel_sec,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int             CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic             blink_phase_q, blink_phase_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [3:0]       digit_bcd;
    logic [6:0]       digit_seg;
    logic             blank;

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    // Leaving adjust mode clears the phase so re-entry always starts visible.
    always_comb begin
        blink_phase_d = 1'b0;
        if (is_adj) begin
            blink_phase_d = blink_phase_q ^ blink_tick;
        end
    end

    always_comb begin
        digit_bcd = bcd_sec_ones;
        case (idx_q)
            DIG_SEC_ONES: digit_bcd = bcd_sec_ones;
            DIG_SEC_TENS: digit_bcd = bcd_sec_tens;
            DIG_MIN_ONES: digit_bcd = bcd_min_ones;
            DIG_MIN_TENS: digit_bcd = bcd_min_tens;
            default:      digit_bcd = bcd_sec_ones;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd_i (digit_bcd),
        .seg_o (digit_seg)
    );

    // idx_q[1] is 0 for the seconds pair, 1 for the minutes pair.
    always_comb begin
        blank = is_adj & blink_phase_q & (idx_q[1] ^ is_sel_sec);
        an_d  = blank ? AN_OFF    : an_onehot_low(idx_q);
        seg_d = blank ? SEG_BLANK : digit_seg;
        dp_d  = (idx_q != DIG_MIN_ONES);
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            idx_q         <= DIG_SEC_ONES;
            blink_phase_q <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver with SCAN_DIV=4
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };
    localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic       clk = 1'b0;
    logic       rst;
    logic       blink_tick;
    logic [3:0] bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones;
    logic       is_adj, is_sel_sec;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    int   m_j;
    logic m_bp;
    string phase_name;

    seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
        .clk_100mhz   (clk),
        .rst          (rst),
        .blink_tick   (blink_tick),
        .bcd_min_tens (bcd_min_tens),
        .bcd_min_ones (bcd_min_ones),
        .bcd_sec_tens (bcd_sec_tens),
        .bcd_sec_ones (bcd_sec_ones),
        .is_adj       (is_adj),
        .is_sel_sec   (is_sel_sec),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    // Monitor: every clock presents a new registered output word.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                tests_failed++;
                $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                         e.name, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    // Push the expected output for the coming edge, advance the model, wait a cycle.
    task automatic step();
        exp_t e;
        int   idx;
        logic [3:0] d;
        logic blank;
        e.name = phase_name;
        if (rst) begin
            e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
            m_j = 0; m_bp = 1'b0;
        end else begin
            idx = (m_j / DIV) % 4;
            case (idx)
                0: d = bcd_sec_ones;
                1: d = bcd_sec_tens;
                2: d = bcd_min_ones;
                default: d = bcd_min_tens;
            endcase
            blank = is_adj && m_bp && (is_sel_sec ? (idx < 2) : (idx >= 2));
            e.an  = blank ? 4'b1111 : AN_TAB[idx];
            e.seg = blank ? 7'b1111111 : SEG_TAB[d];
            e.dp  = (idx == 2) ? 1'b0 : 1'b1;
            m_j++;
            if (!is_adj) m_bp = 1'b0;
            else if (blink_tick) m_bp = ~m_bp;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_digits(input logic [3:0] mt, input logic [3:0] mo,
                              input logic [3:0] st, input logic [3:0] so);
        bcd_min_tens = mt; bcd_min_ones = mo; bcd_sec_tens = st; bcd_sec_ones = so;
    endtask

    task automatic tick();
        blink_tick = 1'b1;
        step();
        blink_tick = 1'b0;
    endtask

    initial begin
        m_j = 0; m_bp = 1'b0;
        rst = 1'b1; blink_tick = 1'b0; is_adj = 1'b0; is_sel_sec = 1'b0;
        set_digits(4'd0, 4'd4, 4'd1, 4'd1);

        phase_name = "reset_hold";
        run(3);
        rst = 1'b0;
        phase_name = "scan_0411";
        run(32);

        phase_name = "scan_9876";
        set_digits(4'd9, 4'd8, 4'd7, 4'd6);
        run(16);
        phase_name = "scan_235A";
        set_digits(4'd2, 4'd3, 4'd5, 4'hA);
        run(16);
        phase_name = "scan_F0C8";
        set_digits(4'hF, 4'd0, 4'hC, 4'd8);
        run(16);

        phase_name = "blink_sec";
        set_digits(4'd0, 4'd4, 4'd1, 4'd1);
        is_adj = 1'b1; is_sel_sec = 1'b1;
        run(5);
        tick();
        run(20);
        tick();
        run(16);

        phase_name = "blink_min";
        tick();
        run(3);
        is_sel_sec = 1'b0;
        run(16);
        phase_name = "adj_drop";
        is_adj = 1'b0;
        run(16);

        phase_name = "tick_on_adj_fall";
        is_adj = 1'b1; is_sel_sec = 1'b1;
        tick();
        run(6);
        is_adj = 1'b0;
        tick();
        is_adj = 1'b1;
        run(16);
        is_adj = 1'b0;

        phase_name = "rst_mid_scan";
        while (((m_j / DIV) % 4) != 2) step();
        run(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        phase_name = "rst_restart";
        run(20);

        @(posedge clk);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
